clken_rst_seq: RTL and testbench
================================

CLKEN_RST_SEQ -- requirements
Module: clken_rst_seq

Interface
REQ-001 NUM_CH, 4: number of independent clock-enable channels (1..8).
REQ-002 CNT_W, 4: width of each per-channel divide-ratio field and counter.
REQ-003 SYNC_STAGES, 2: flip-flop stages on each asynchronous input (minimum 2).
REQ-004 HOLD_CYCLES, 64: cycles both resets stay asserted after lock and button are both good (minimum 1).
REQ-005 CPU_DELAY, 16: cycles between peripheral reset release and CPU reset release (minimum 1).
REQ-006 clk  in  1  system clock; the block has one clock only.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 pll_locked  in  1  PLL lock indication, asynchronous.
REQ-009 ext_reset_n  in  1  board reset switch/button, asynchronous, active-low.
REQ-010 div_val  in  NUM_CH*CNT_W  per-channel divide ratio d; channel i uses bits [i*CNT_W +: CNT_W]; period is d+1 cycles.
REQ-011 clk_en  out  NUM_CH  per-channel single-cycle enable pulse.
REQ-012 clk_div  out  NUM_CH  per-channel divided square-wave level.
REQ-013 rst_periph_n  out  1  peripheral reset, active-low, registered.
REQ-014 rst_cpu_n  out  1  CPU reset, active-low, registered.
REQ-015 seq_state  out  2  current sequencer state: 0 WAIT_LOCK, 1 HOLD, 2 PERIPH, 3 RUN.

Function
REQ-016 pll_locked and ext_reset_n SHALL each pass through SYNC_STAGES flip-flops; "good" means synced lock = 1 and synced ext_reset_n = 1.
REQ-017 WAIT_LOCK: resets asserted, channels idle; on good, go to HOLD and load the sequence counter with HOLD_CYCLES-1.
REQ-018 HOLD: decrement the sequence counter; at 0, go to PERIPH, set rst_periph_n=1, and load the counter with CPU_DELAY-1.
REQ-019 PERIPH: decrement the sequence counter; at 0, go to RUN and set rst_cpu_n=1.
REQ-020 RUN: hold; both resets stay deasserted.
REQ-021 In any state, loss of good SHALL return the sequencer to WAIT_LOCK on the next clock, with rst_periph_n=0 and rst_cpu_n=0 on that same clock.
REQ-022 Loss of good has priority over every counter expiry in the same cycle.
REQ-023 Channels SHALL run only in PERIPH and RUN; in other states, counters=0, clk_en=0, clk_div=0.
REQ-024 Channel counter: starts at 0 on the first PERIPH cycle; increments each cycle; wraps to 0 after reaching the latched d.
REQ-025 clk_en[i]=1 exactly in cycles where counter[i]=0, so the first pulse is on the first PERIPH cycle.
REQ-026 clk_div[i]=1 when counter[i] >= (d+1)>>1, computed in CNT_W+1 bits. For d=3 this gives 0,0,1,1.
REQ-027 d=0: clk_en[i] stays at 1 and clk_div[i] stays at 1 while running.
REQ-028 Maximum d (all ones) gives period 2^CNT_W; there SHALL be no overflow beyond the wrap.
REQ-029 d SHALL be latched on the first PERIPH cycle and at each wrap; a mid-period change of div_val affects only the next period.
REQ-030 All outputs SHALL be registered; clk_en/clk_div for a counter value appear on the same cycle as that value.

Reset
REQ-031 rst=1 SHALL asynchronously force the following values:
- seq_state=WAIT_LOCK
- all synchronizer flops=0
- sequence counter=0
- channel counters=0 and latched d=0
- clk_en=0, clk_div=0
- rst_periph_n=0, rst_cpu_n=0
REQ-032 After rst deasserts, the sequence restarts from WAIT_LOCK regardless of prior state.

Structure
REQ-033 A shared package SHALL hold the seq_state encoding constants (WAIT_LOCK, HOLD, PERIPH, RUN) and the sequence counter width, computed as clog2 of max(HOLD_CYCLES, CPU_DELAY).
REQ-034 One sub-module clken_chan SHALL implement a single divider channel (counter, ratio latch, clk_en, clk_div); it is instantiated NUM_CH times via generate.

Verification
REQ-035 Lock-up sequence: rst pulse, then pll_locked=1, ext_reset_n=1 -> rst_periph_n rises SYNC_STAGES+1+64 cycles after the lock edge; rst_cpu_n rises 16 cycles later; seq_state goes 0,1,2,3.
REQ-036 Divider: d=3 on channel 0 in RUN -> clk_en pulses every 4 cycles; clk_div pattern 0,0,1,1.
REQ-037 Divider extremes: d=0 on channel 1 gives clk_en constantly 1; d=15 on channel 2 gives period 16.
REQ-038 Ratio change: div_val ch0 3->1 mid-period -> current 4-cycle period completes, then period becomes 2.
REQ-039 Lock drop: pll_locked to 0 for 1 cycle in RUN -> after synchronizer delay, both resets go to 0 next clock, clk_en goes to 0, seq_state=0, and the full sequence replays.
REQ-040 Simultaneous events: ext_reset_n to 0 on the HOLD expiry cycle -> WAIT_LOCK and rst_periph_n stays 0. Separately, rst asserted mid-PERIPH -> all outputs at reset values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/clken_rst_seq_pkg.sv
// Shared types and helpers for the clock-enable / reset sequencer.
package clken_rst_seq_pkg;

    // Sequencer state encoding, also exported on seq_state.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        PERIPH    = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    localparam int HOLD_CYCLES_DEF = 64;
    localparam int CPU_DELAY_DEF   = 16;

    // The sequence counter only ever holds a load value of (max - 1),
    // so clog2(max) bits suffice; never narrower than one bit.
    function automatic int seq_cnt_width(input int hold, input int delay);
        int m;
        m = (hold > delay) ? hold : delay;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

    localparam int SEQ_CNT_W = seq_cnt_width(HOLD_CYCLES_DEF, CPU_DELAY_DEF);

endpackage

// File: rtl/clken_rst_seq_if.sv
// Board-side bundle: async status inputs, divide ratios, enables and resets.
interface clken_rst_seq_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 4
);
    logic                    pll_locked;
    logic                    ext_reset_n;
    logic [NUM_CH*CNT_W-1:0] div_val;
    logic [NUM_CH-1:0]       clk_en;
    logic [NUM_CH-1:0]       clk_div;
    logic                    rst_periph_n;
    logic                    rst_cpu_n;
    logic [1:0]              seq_state;

    modport master (
        output pll_locked, ext_reset_n, div_val,
        input  clk_en, clk_div, rst_periph_n, rst_cpu_n, seq_state
    );

    modport slave (
        input  pll_locked, ext_reset_n, div_val,
        output clk_en, clk_div, rst_periph_n, rst_cpu_n, seq_state
    );
endinterface

// File: rtl/clken_rst_seq_chan.sv
// One divider channel: counter, latched ratio, enable pulse and square wave.
module clken_chan #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,   // next cycle is the first PERIPH cycle
    input  logic             active,  // next cycle stays in PERIPH/RUN
    input  logic [CNT_W-1:0] div,
    output logic             clk_en,
    output logic             clk_div
);
    logic [CNT_W-1:0] cnt, d_lat;
    logic [CNT_W-1:0] nxt_cnt, nxt_d;
    logic [CNT_W:0]   half;
    logic             run;

    // Next counter/ratio; the ratio is only re-sampled at start and at wrap.
    always_comb begin
        nxt_cnt = '0;
        nxt_d   = '0;
        run     = 1'b0;
        if (start) begin
            nxt_d = div;
            run   = 1'b1;
        end else if (active) begin
            run = 1'b1;
            if (cnt == d_lat) begin
                nxt_d = div;
            end else begin
                nxt_cnt = cnt + 1'b1;
                nxt_d   = d_lat;
            end
        end
        // Extra bit so that d = all ones does not overflow (d+1).
        half = ({1'b0, nxt_d} + {{CNT_W{1'b0}}, 1'b1}) >> 1;
    end

    // Outputs are registered alongside the counter value they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            d_lat   <= '0;
            clk_en  <= 1'b0;
            clk_div <= 1'b0;
        end else begin
            cnt     <= nxt_cnt;
            d_lat   <= nxt_d;
            clk_en  <= run && (nxt_cnt == '0);
            clk_div <= run && ({1'b0, nxt_cnt} >= half);
        end
    end
endmodule

// File: rtl/clken_rst_seq.sv
// Power-up reset sequencer with per-channel clock-enable dividers.
module clken_rst_seq
    import clken_rst_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CPU_DELAY   = CPU_DELAY_DEF
) (
    input  logic                clk,
    input  logic                rst,
    clken_rst_seq_if.slave      bus
);
    localparam int SCW = seq_cnt_width(HOLD_CYCLES, CPU_DELAY);
    localparam logic [SCW-1:0] HOLD_LOAD = SCW'(HOLD_CYCLES - 1);
    localparam logic [SCW-1:0] CPU_LOAD  = SCW'(CPU_DELAY - 1);

    logic [SYNC_STAGES-1:0] lock_sync, ext_sync;
    logic                   good;
    seq_state_t             state;
    logic [SCW-1:0]         seq_cnt;
    logic                   periph_n, cpu_n;
    logic                   chan_start, chan_active;
    logic [NUM_CH-1:0]      en_vec, div_vec;

    // Bring both asynchronous status inputs into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_sync <= '0;
            ext_sync  <= '0;
        end else begin
            lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.pll_locked};
            ext_sync  <= {ext_sync[SYNC_STAGES-2:0], bus.ext_reset_n};
        end
    end

    assign good = lock_sync[SYNC_STAGES-1] & ext_sync[SYNC_STAGES-1];

    // Reset sequencer; losing good overrides any counter expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= WAIT_LOCK;
            seq_cnt  <= '0;
            periph_n <= 1'b0;
            cpu_n    <= 1'b0;
        end else if (!good) begin
            state    <= WAIT_LOCK;
            seq_cnt  <= '0;
            periph_n <= 1'b0;
            cpu_n    <= 1'b0;
        end else begin
            case (state)
                WAIT_LOCK: begin
                    state   <= HOLD;
                    seq_cnt <= HOLD_LOAD;
                end
                HOLD: begin
                    if (seq_cnt == '0) begin
                        state    <= PERIPH;
                        periph_n <= 1'b1;
                        seq_cnt  <= CPU_LOAD;
                    end else begin
                        seq_cnt <= seq_cnt - 1'b1;
                    end
                end
                PERIPH: begin
                    if (seq_cnt == '0) begin
                        state <= RUN;
                        cpu_n <= 1'b1;
                    end else begin
                        seq_cnt <= seq_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Channels look one cycle ahead so their outputs line up with the state.
    assign chan_start  = good && (state == HOLD) && (seq_cnt == '0);
    assign chan_active = good && ((state == PERIPH) || (state == RUN));

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clken_chan #(.CNT_W(CNT_W)) u_chan (
            .clk     (clk),
            .rst     (rst),
            .start   (chan_start),
            .active  (chan_active),
            .div     (bus.div_val[i*CNT_W +: CNT_W]),
            .clk_en  (en_vec[i]),
            .clk_div (div_vec[i])
        );
    end

    assign bus.clk_en       = en_vec;
    assign bus.clk_div      = div_vec;
    assign bus.rst_periph_n = periph_n;
    assign bus.rst_cpu_n    = cpu_n;
    assign bus.seq_state    = state;
endmodule

// File: tb/tb_clken_rst_seq.sv
// Directed bench for clken_rst_seq: lock-up, dividers, ratio change, lock
// drop, simultaneous events and asynchronous reset.
module tb_clken_rst_seq;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    clken_rst_seq_if #(.NUM_CH(4), .CNT_W(4)) bus_if ();

    clken_rst_seq #(
        .NUM_CH(4), .CNT_W(4), .SYNC_STAGES(2), .HOLD_CYCLES(64), .CPU_DELAY(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock: outputs are sampled and inputs driven at the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst                = 1'b1;
        bus_if.pll_locked  = 1'b0;
        bus_if.ext_reset_n = 1'b1;
        bus_if.div_val     = 16'h5F03;   // ch3=5 ch2=15 ch1=0 ch0=3
        #1;
        checks++;
        if (bus_if.seq_state !== 2'd0 || bus_if.rst_periph_n !== 1'b0 ||
            bus_if.rst_cpu_n !== 1'b0 || bus_if.clk_en !== 4'h0 || bus_if.clk_div !== 4'h0) begin
            errors++;
            $display("FAIL reset_vals state=%0d pn=%b cn=%b en=%h div=%h exp 0/0/0/0/0",
                     bus_if.seq_state, bus_if.rst_periph_n, bus_if.rst_cpu_n,
                     bus_if.clk_en, bus_if.clk_div);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (bus_if.seq_state !== 2'd0 || bus_if.rst_periph_n !== 1'b0) begin
                errors++;
                $display("FAIL wait_no_lock k=%0d state=%0d pn=%b exp 0/0",
                         k, bus_if.seq_state, bus_if.rst_periph_n);
            end
        end
    endtask

    // Lock edge at tick 0: HOLD at 3, PERIPH at 67, RUN at 83.
    task automatic test_lockup();
        bus_if.pll_locked = 1'b1;
        for (int k = 1; k <= 83; k++) begin
            tick();
            if (k == 2 || k == 3 || k == 66 || k == 67 || k == 82 || k == 83) begin
                logic [1:0] es;
                logic       ep, ec;
                es = (k <= 2) ? 2'd0 : (k <= 66) ? 2'd1 : (k <= 82) ? 2'd2 : 2'd3;
                ep = (k >= 67);
                ec = (k >= 83);
                checks++;
                if (bus_if.seq_state !== es || bus_if.rst_periph_n !== ep || bus_if.rst_cpu_n !== ec) begin
                    errors++;
                    $display("FAIL lockup k=%0d got state=%0d pn=%b cn=%b exp %0d/%b/%b",
                             k, bus_if.seq_state, bus_if.rst_periph_n, bus_if.rst_cpu_n, es, ep, ec);
                end
            end
            if (k == 66 || k == 67) begin
                logic [3:0] een, ediv;
                een  = (k == 67) ? 4'b1111 : 4'b0000;
                ediv = (k == 67) ? 4'b0010 : 4'b0000;
                checks++;
                if (bus_if.clk_en !== een || bus_if.clk_div !== ediv) begin
                    errors++;
                    $display("FAIL first_pulse k=%0d en=%h div=%h exp %h/%h",
                             k, bus_if.clk_en, bus_if.clk_div, een, ediv);
                end
            end
        end
    endtask

    // Entry point: 16 cycles since the first PERIPH cycle.
    task automatic test_divider();
        for (int i = 0; i < 32; i++) begin
            int n;
            logic [3:0] een, ediv;
            tick();
            n = 17 + i;
            een  = {(n % 6) == 0, (n % 16) == 0, 1'b1, (n % 4) == 0};
            ediv = {(n % 6) >= 3, (n % 16) >= 8, 1'b1, (n % 4) >= 2};
            checks++;
            if (bus_if.clk_en !== een || bus_if.clk_div !== ediv) begin
                errors++;
                $display("FAIL divider n=%0d en=%h div=%h exp %h/%h",
                         n, bus_if.clk_en, bus_if.clk_div, een, ediv);
            end
        end
    endtask

    // ch0 at count 1 of a d=3 period; switching to d=1 takes effect at wrap.
    task automatic test_ratio_change();
        logic [5:0] exp_en, exp_div;
        exp_en  = 6'b010100;   // index 0 first: cnt 2,3,0,1,0,1
        exp_div = 6'b101011;
        tick();
        bus_if.div_val[3:0] = 4'd1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus_if.clk_en[0] !== exp_en[i] || bus_if.clk_div[0] !== exp_div[i]) begin
                errors++;
                $display("FAIL ratio_change i=%0d en0=%b div0=%b exp %b/%b",
                         i, bus_if.clk_en[0], bus_if.clk_div[0], exp_en[i], exp_div[i]);
            end
        end
        bus_if.div_val[3:0] = 4'd3;
    endtask

    task automatic test_lock_drop();
        bus_if.pll_locked = 1'b0;
        tick();
        bus_if.pll_locked = 1'b1;
        tick();
        checks++;
        if (bus_if.seq_state !== 2'd3 || bus_if.rst_cpu_n !== 1'b1) begin
            errors++;
            $display("FAIL drop_sync_delay state=%0d cn=%b exp 3/1", bus_if.seq_state, bus_if.rst_cpu_n);
        end
        tick();
        checks++;
        if (bus_if.seq_state !== 2'd0 || bus_if.rst_periph_n !== 1'b0 || bus_if.rst_cpu_n !== 1'b0 ||
            bus_if.clk_en !== 4'h0 || bus_if.clk_div !== 4'h0) begin
            errors++;
            $display("FAIL drop_reset state=%0d pn=%b cn=%b en=%h div=%h exp 0/0/0/0/0",
                     bus_if.seq_state, bus_if.rst_periph_n, bus_if.rst_cpu_n,
                     bus_if.clk_en, bus_if.clk_div);
        end
        // Replay: HOLD at 4, PERIPH at 68, RUN at 84 (ticks since the drop).
        for (int k = 4; k <= 84; k++) begin
            tick();
            if (k == 4 || k == 67 || k == 68 || k == 83 || k == 84) begin
                logic [1:0] es;
                es = (k <= 67) ? 2'd1 : (k <= 83) ? 2'd2 : 2'd3;
                checks++;
                if (bus_if.seq_state !== es || bus_if.rst_periph_n !== (k >= 68) ||
                    bus_if.rst_cpu_n !== (k >= 84)) begin
                    errors++;
                    $display("FAIL replay k=%0d state=%0d pn=%b cn=%b exp %0d/%b/%b",
                             k, bus_if.seq_state, bus_if.rst_periph_n, bus_if.rst_cpu_n,
                             es, (k >= 68), (k >= 84));
                end
            end
        end
    endtask

    // ext_reset_n drops so that good falls exactly in the HOLD expiry cycle.
    task automatic test_simultaneous();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 68; k++) begin
            tick();
            if (k == 64) bus_if.ext_reset_n = 1'b0;
            if (k == 66) begin
                checks++;
                if (bus_if.seq_state !== 2'd1) begin
                    errors++;
                    $display("FAIL hold_expiry_pre state=%0d exp 1", bus_if.seq_state);
                end
            end
            if (k == 67 || k == 68) begin
                checks++;
                if (bus_if.seq_state !== 2'd0 || bus_if.rst_periph_n !== 1'b0 || bus_if.clk_en !== 4'h0) begin
                    errors++;
                    $display("FAIL hold_expiry_drop k=%0d state=%0d pn=%b en=%h exp 0/0/0",
                             k, bus_if.seq_state, bus_if.rst_periph_n, bus_if.clk_en);
                end
            end
        end
        bus_if.ext_reset_n = 1'b1;
    endtask

    task automatic test_async_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 70; k++) tick();
        checks++;
        if (bus_if.seq_state !== 2'd2 || bus_if.rst_periph_n !== 1'b1 || bus_if.rst_cpu_n !== 1'b0) begin
            errors++;
            $display("FAIL mid_periph state=%0d pn=%b cn=%b exp 2/1/0",
                     bus_if.seq_state, bus_if.rst_periph_n, bus_if.rst_cpu_n);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus_if.seq_state !== 2'd0 || bus_if.rst_periph_n !== 1'b0 || bus_if.rst_cpu_n !== 1'b0 ||
            bus_if.clk_en !== 4'h0 || bus_if.clk_div !== 4'h0) begin
            errors++;
            $display("FAIL async_reset state=%0d pn=%b cn=%b en=%h div=%h exp 0/0/0/0/0",
                     bus_if.seq_state, bus_if.rst_periph_n, bus_if.rst_cpu_n,
                     bus_if.clk_en, bus_if.clk_div);
        end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_lockup();
        test_divider();
        test_ratio_change();
        test_lock_drop();
        test_simultaneous();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
